// File: rtl/apb_pkg.sv
// Shared state encoding, error causes and address/strobe helpers for the APB register bank.
package apb_pkg;

    typedef logic [1:0] apb_state_t;

    localparam apb_state_t ST_IDLE = 2'd0;
    localparam apb_state_t ST_WAIT = 2'd1;
    localparam apb_state_t ST_RESP = 2'd2;

    typedef enum logic [2:0] {
        ERR_NONE,
        ERR_RANGE,
        ERR_MISALIGN,
        ERR_RO_WRITE,
        ERR_STRB_READ
    } apb_err_t;

    function automatic bit legal_data_width(input int unsigned w);
        return (w == 8) || (w == 16) || (w == 32) || (w == 64);
    endfunction

    // Helpers work on a 64-bit container so any address width up to 64 fits.
    function automatic logic [63:0] addr_to_index(input logic [63:0] addr,
                                                  input int unsigned offs_bits);
        return addr >> offs_bits;
    endfunction

    function automatic logic [63:0] byte_offset(input logic [63:0] addr,
                                                input int unsigned offs_bits);
        return addr & ((64'd1 << offs_bits) - 64'd1);
    endfunction

    function automatic logic [63:0] merge_bytes(input logic [63:0] old_word,
                                                input logic [63:0] new_word,
                                                input logic [7:0]  strb);
        logic [63:0] res;
        res = old_word;
        for (int b = 0; b < 8; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// Register storage for the APB register bank: RW words with byte-strobe merge,
// RO words passed straight through from ro_in, and a read mux over both.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_NUM    = 16,
    parameter int RO_NUM     = 4,
    parameter int IDX_W      = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         wr_en,
    input  logic [IDX_W-1:0]             wr_idx,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic [DATA_WIDTH/8-1:0]      wr_strb,
    input  logic [IDX_W-1:0]             rd_idx,
    input  logic [RO_NUM*DATA_WIDTH-1:0] ro_in,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic [REG_NUM*DATA_WIDTH-1:0] reg_q
);

    for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_reg
        if (gi < RO_NUM) begin : g_ro
            assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = ro_in[gi*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_rw
            logic [DATA_WIDTH-1:0] q;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    q <= '0;
                end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    q <= DATA_WIDTH'(merge_bytes(64'(q), 64'(wr_data), 8'(wr_strb)));
                end
            end

            assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = q;
        end
    end

    // Indices beyond REG_NUM (non power-of-two banks) read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            if (rd_idx == IDX_W'(i)) rd_data = reg_q[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/apb_slave_regbank.sv
// APB slave register bank with programmable wait states and error response.
// Optional byte strobes are enabled with the APB_WSTRB_EN macro.
module apb_slave_regbank
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int REG_NUM     = 16,
    parameter int RO_NUM      = 4,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          sel,
    input  logic                          enable,
    input  logic [ADDR_WIDTH-1:0]         addr,
    input  logic                          write,
    input  logic [DATA_WIDTH-1:0]         wdata,
`ifdef APB_WSTRB_EN
    input  logic [DATA_WIDTH/8-1:0]       strb,
`endif
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          ready,
    output logic                          slave_error,
    input  logic [RO_NUM*DATA_WIDTH-1:0]  ro_in,
    output logic [REG_NUM*DATA_WIDTH-1:0] reg_q
);

    localparam int         NB        = DATA_WIDTH / 8;
    localparam int         OFFS_BITS = $clog2(NB);
    localparam int         IDX_W     = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    if (!legal_data_width(DATA_WIDTH)) begin : g_bad_width
        $error("apb_slave_regbank: DATA_WIDTH must be 8, 16, 32 or 64");
    end
    if (RO_NUM >= REG_NUM) begin : g_bad_ro
        $error("apb_slave_regbank: RO_NUM must be smaller than REG_NUM");
    end
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("apb_slave_regbank: WAIT_CYCLES must be in 0..15");
    end

    apb_state_t            state;
    logic [3:0]            cnt;
    logic                  wr_q;
    logic                  err_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [NB-1:0]         strb_q;
    logic [DATA_WIDTH-1:0] rd_hold;

    logic [63:0]           cur_idx;
    logic [63:0]           cur_off;
    apb_err_t              cur_err;
    logic [NB-1:0]         cur_strb;
    logic [DATA_WIDTH-1:0] rf_rd_data;
    logic [DATA_WIDTH-1:0] rd_now;
    logic                  capture;
    logic                  commit;

`ifdef APB_WSTRB_EN
    assign cur_strb = strb;
`else
    assign cur_strb = '1;
`endif

    assign cur_idx = addr_to_index(64'(addr), OFFS_BITS);
    assign cur_off = byte_offset(64'(addr), OFFS_BITS);

    // Error decode of the live setup-phase bus; the first matching cause wins.
    always_comb begin
        cur_err = ERR_NONE;
        if (cur_idx >= 64'(REG_NUM)) begin
            cur_err = ERR_RANGE;
        end else if (cur_off != 64'd0) begin
            cur_err = ERR_MISALIGN;
        end else if (write && (cur_idx < 64'(RO_NUM))) begin
            cur_err = ERR_RO_WRITE;
`ifdef APB_WSTRB_EN
        end else if (!write && (strb != '0)) begin
            cur_err = ERR_STRB_READ;
`endif
        end
    end

    assign rd_now  = ((cur_err != ERR_NONE) || write) ? '0 : rf_rd_data;
    assign capture = sel && !enable && ((state == ST_IDLE) || (state == ST_RESP));
    assign commit  = (state == ST_RESP) && sel && enable && ready && wr_q && !err_q;

    apb_slave_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_NUM    (REG_NUM),
        .RO_NUM     (RO_NUM),
        .IDX_W      (IDX_W)
    ) u_regfile (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (commit),
        .wr_idx  (idx_q),
        .wr_data (wdata_q),
        .wr_strb (strb_q),
        .rd_idx  (cur_idx[IDX_W-1:0]),
        .ro_in   (ro_in),
        .rd_data (rf_rd_data),
        .reg_q   (reg_q)
    );

    // Read data is snapshotted at the setup edge so RO status values are
    // those seen when the transfer started, not when ready finally rises.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            ready       <= 1'b0;
            slave_error <= 1'b0;
            rdata       <= '0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            rd_hold     <= '0;
        end else begin
            ready       <= 1'b0;
            slave_error <= 1'b0;
            rdata       <= '0;
            if (capture) begin
                wr_q    <= write;
                err_q   <= (cur_err != ERR_NONE);
                idx_q   <= cur_idx[IDX_W-1:0];
                wdata_q <= wdata;
                strb_q  <= cur_strb;
                rd_hold <= rd_now;
                cnt     <= WAIT_INIT;
                if (WAIT_CYCLES == 0) begin
                    state       <= ST_RESP;
                    ready       <= 1'b1;
                    slave_error <= (cur_err != ERR_NONE);
                    rdata       <= rd_now;
                end else begin
                    state <= ST_WAIT;
                end
            end else begin
                case (state)
                    ST_WAIT: begin
                        if (!sel) begin
                            state <= ST_IDLE;
                        end else if (cnt == 4'd1) begin
                            state       <= ST_RESP;
                            ready       <= 1'b1;
                            slave_error <= err_q;
                            rdata       <= rd_hold;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rstn) slave_error |-> ready);

endmodule
